// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory controller: funct3 codes, FSM encoding,
// request capture record and byte-lane mask helper.
package mem_pkg;
  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [2:0]  funct3;
    logic [31:0] wdata;
  } mem_req_t;

  // funct3[1:0] encodes the access width for both loads and stores
  function automatic logic [NUM_LANES-1:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   lane_mask = NUM_LANES'(1) << off;
      2'b01:   lane_mask = off[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction
endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering: store mask/replicated data, load extraction
// with sign/zero extension, and legality checks for the access.
module lsu_align
  import mem_pkg::*;
(
  input  logic [2:0]                         funct3,
  input  logic                               we,
  input  logic [1:0]                         off,
  input  logic [31:0]                        wdata,
  input  logic [31:0]                        raw,
  output logic [NUM_LANES-1:0]               mask,
  output logic [NUM_LANES-1:0][LANE_W-1:0]   wdata_al,
  output logic [31:0]                        rdata_ext,
  output logic                               misalign,
  output logic                               bad_f3
);
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    mask = lane_mask(funct3, off);
    b    = raw[{off, 3'b000} +: 8];
    h    = off[1] ? raw[31:16] : raw[15:0];
    case (funct3)
      F3_B:    rdata_ext = {{24{b[7]}}, b};
      F3_H:    rdata_ext = {{16{h[15]}}, h};
      F3_BU:   rdata_ext = {24'b0, b};
      F3_HU:   rdata_ext = {16'b0, h};
      default: rdata_ext = raw;
    endcase
    misalign = (funct3[1:0] == 2'b01 && off[0]) || (funct3[1:0] == 2'b10 && off != 2'b00);
    bad_f3   = we ? (funct3 > F3_W)
                  : (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111);
  end

  // Narrow stores replicate the datum across lanes; the mask picks the target lane(s)
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign wdata_al[l] = (funct3[1:0] == 2'b00) ? wdata[7:0] :
                         (funct3[1:0] == 2'b01) ? wdata[(l % 2) * LANE_W +: LANE_W] :
                                                  wdata[l * LANE_W +: LANE_W];
  end
endmodule

// File: rtl/data_mem_ctrl.sv
// Multi-cycle data-memory controller: captures an LSU request, waits LATENCY
// cycles, performs a masked store or extended load, then pulses valid once.
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int DEPTH     = 256,
  parameter int LATENCY   = 1,
  parameter     INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        valid,
  output logic        err,
  output logic        stall
);
  localparam int AW = $clog2(DEPTH);

  logic [NUM_LANES-1:0][LANE_W-1:0] mem [0:DEPTH-1];

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic        err_n, capture, do_access, legal;
  mem_req_t    req_q, live, cur;
  logic [AW-1:0] idx;
  logic [31:0] raw, rdata_ext;
  logic [NUM_LANES-1:0] mask;
  logic [NUM_LANES-1:0][LANE_W-1:0] wdata_al;
  logic        misalign, bad_f3, unused_hi;

  assign live = '{we: we, addr: addr, funct3: funct3, wdata: wdata};
  // Legality is judged on the live inputs at capture; afterwards only the held copy matters
  assign cur       = (state == S_IDLE) ? live : req_q;
  assign idx       = cur.addr[AW+1:2];
  assign unused_hi = ^cur.addr[31:AW+2];
  assign raw       = mem[idx];
  assign legal     = ~(misalign | bad_f3);

  lsu_align u_align (
    .funct3    (cur.funct3),
    .we        (cur.we),
    .off       (cur.addr[1:0]),
    .wdata     (cur.wdata),
    .raw       (raw),
    .mask      (mask),
    .wdata_al  (wdata_al),
    .rdata_ext (rdata_ext),
    .misalign  (misalign),
    .bad_f3    (bad_f3)
  );

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    err_n     = err;
    capture   = 1'b0;
    do_access = 1'b0;
    case (state)
      S_IDLE: if (req) begin
        capture = 1'b1;
        if (legal) begin
          state_n = S_BUSY;
          cnt_n   = 4'(LATENCY - 1);
        end else begin
          state_n = S_DONE;
          err_n   = 1'b1;
        end
      end
      S_BUSY: if (cnt == 4'd0) begin
        do_access = 1'b1;
        state_n   = S_DONE;
      end else begin
        cnt_n = cnt - 4'd1;
      end
      default: begin
        state_n = S_IDLE;
        err_n   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      err   <= 1'b0;
      rdata <= 32'd0;
      req_q <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      err   <= err_n;
      if (capture) req_q <= live;
      if (do_access && !req_q.we) rdata <= rdata_ext;
    end
  end

  // Array has no reset; reset holds the FSM in IDLE so no write can fire
  always_ff @(posedge clk) begin
    if (do_access && req_q.we)
      for (int l = 0; l < NUM_LANES; l++)
        if (mask[l]) mem[idx][l] <= wdata_al[l];
  end

  assign valid = (state == S_DONE);
  assign stall = req & ~valid;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench: table of accesses against a LATENCY=2 instance, plus hand
// sequences for back-to-back aliasing and mid-access reset on a LATENCY=4 instance.
module tb_data_mem_ctrl;
  logic        clk = 0;
  logic        rst_a = 0, rst_b = 0, req_a = 0, req_b = 0;
  logic        we = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic [2:0]  funct3 = 0;
  logic [31:0] rdata_a, rdata_b;
  logic        valid_a, valid_b, err_a, err_b, stall_a, stall_b;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.DEPTH(256), .LATENCY(2)) u_a (
    .clk(clk), .rst(rst_a), .req(req_a), .we(we), .addr(addr), .funct3(funct3),
    .wdata(wdata), .rdata(rdata_a), .valid(valid_a), .err(err_a), .stall(stall_a));

  data_mem_ctrl #(.DEPTH(256), .LATENCY(4)) u_b (
    .clk(clk), .rst(rst_b), .req(req_b), .we(we), .addr(addr), .funct3(funct3),
    .wdata(wdata), .rdata(rdata_b), .valid(valid_b), .err(err_b), .stall(stall_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Called just after a negedge; returns at the negedge where valid is seen.
  task automatic access(input bit sel, input logic w, input logic [31:0] a, input logic [2:0] f,
                        input logic [31:0] wd, output logic [31:0] rd, output logic e,
                        output int cyc, output bit stall_ok);
    logic v, s;
    we = w; addr = a; funct3 = f; wdata = wd;
    if (sel) req_b = 1; else req_a = 1;
    cyc = 0; stall_ok = 1;
    #1;
    v = sel ? valid_b : valid_a; s = sel ? stall_b : stall_a;
    if (!v && !s) stall_ok = 0;
    do begin
      @(posedge clk); @(negedge clk);
      cyc++;
      v = sel ? valid_b : valid_a; s = sel ? stall_b : stall_a;
      if (v == s) stall_ok = 0;
    end while (!v && cyc < 40);
    rd = sel ? rdata_b : rdata_a;
    e  = sel ? err_b : err_a;
    req_a = 0; req_b = 0;
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [2:0]  f;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_cyc;
  } vec_t;

  vec_t vt[21];
  logic [31:0] rd;
  logic e;
  int cyc, cyc2;
  bit sok, seen;

  initial begin
    vt[0]  = '{1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 32'h0,        1'b0, 3};
    vt[1]  = '{1'b0, 32'h10, 3'b010, 32'h0,        32'hDEADBEEF, 1'b0, 3};
    vt[2]  = '{1'b1, 32'h13, 3'b000, 32'h80,       32'hDEADBEEF, 1'b0, 3};
    vt[3]  = '{1'b0, 32'h10, 3'b010, 32'h0,        32'h80ADBEEF, 1'b0, 3};
    vt[4]  = '{1'b0, 32'h13, 3'b000, 32'h0,        32'hFFFFFF80, 1'b0, 3};
    vt[5]  = '{1'b0, 32'h13, 3'b100, 32'h0,        32'h00000080, 1'b0, 3};
    vt[6]  = '{1'b1, 32'h20, 3'b010, 32'h0,        32'h00000080, 1'b0, 3};
    vt[7]  = '{1'b1, 32'h22, 3'b001, 32'h8001,     32'h00000080, 1'b0, 3};
    vt[8]  = '{1'b0, 32'h22, 3'b001, 32'h0,        32'hFFFF8001, 1'b0, 3};
    vt[9]  = '{1'b0, 32'h22, 3'b101, 32'h0,        32'h00008001, 1'b0, 3};
    vt[10] = '{1'b0, 32'h20, 3'b010, 32'h0,        32'h80010000, 1'b0, 3};
    vt[11] = '{1'b0, 32'h21, 3'b010, 32'h0,        32'h80010000, 1'b1, 1};
    vt[12] = '{1'b1, 32'h22, 3'b010, 32'h5555,     32'h80010000, 1'b1, 1};
    vt[13] = '{1'b0, 32'h20, 3'b010, 32'h0,        32'h80010000, 1'b0, 3};
    vt[14] = '{1'b0, 32'h22, 3'b000, 32'h0,        32'h00000001, 1'b0, 3};
    vt[15] = '{1'b0, 32'h23, 3'b001, 32'h0,        32'h00000001, 1'b1, 1};
    vt[16] = '{1'b0, 32'h20, 3'b011, 32'h0,        32'h00000001, 1'b1, 1};
    vt[17] = '{1'b1, 32'h24, 3'b100, 32'h1234,     32'h00000001, 1'b1, 1};
    vt[18] = '{1'b1, 32'h20, 3'b001, 32'hFFFF1234, 32'h00000001, 1'b0, 3};
    vt[19] = '{1'b1, 32'h21, 3'b000, 32'h777777AB, 32'h00000001, 1'b0, 3};
    vt[20] = '{1'b0, 32'h21, 3'b000, 32'h0,        32'hFFFFFFAB, 1'b0, 3};

    repeat (3) @(negedge clk);
    chk("rst_rdata", rdata_a, 32'h0);
    chk("rst_valid", valid_a, 1'b0);
    chk("rst_err",   err_a,   1'b0);
    chk("rst_stall", stall_a, 1'b0);
    rst_a = 1; rst_b = 1;
    @(negedge clk);

    foreach (vt[i]) begin
      access(0, vt[i].w, vt[i].a, vt[i].f, vt[i].wd, rd, e, cyc, sok);
      chk($sformatf("v%0d_rdata", i), rd, vt[i].exp_rd);
      chk($sformatf("v%0d_err", i), e, vt[i].exp_err);
      chk($sformatf("v%0d_cycle", i), cyc, vt[i].exp_cyc);
      chk($sformatf("v%0d_stall", i), sok, 1'b1);
      @(negedge clk);
      chk($sformatf("v%0d_pulse", i), {err_a, valid_a}, 2'b00);
    end

    // Back-to-back loads, second one aliased past the array size
    access(0, 1'b0, 32'h10, 3'b010, 32'h0, rd, e, cyc, sok);
    chk("b2b_first_rdata", rd, 32'h80ADBEEF);
    chk("b2b_first_cycle", cyc, 3);
    access(0, 1'b0, 32'h10 + 256 * 4, 3'b010, 32'h0, rd, e, cyc2, sok);
    chk("b2b_alias_rdata", rd, 32'h80ADBEEF);
    chk("b2b_spacing", cyc2, 4);
    chk("b2b_err", e, 1'b0);
    @(negedge clk);

    // LATENCY=4 instance: store, then abort a second store with reset
    access(1, 1'b1, 32'h30, 3'b010, 32'hA5A5A5A5, rd, e, cyc, sok);
    chk("l4_store_cycle", cyc, 5);
    chk("l4_store_err", e, 1'b0);
    @(negedge clk);
    we = 1; addr = 32'h30; funct3 = 3'b010; wdata = 32'h1; req_b = 1;
    seen = 0;
    repeat (2) begin
      @(posedge clk); @(negedge clk);
      if (valid_b) seen = 1;
    end
    rst_b = 0;
    #1;
    chk("abort_valid", valid_b, 1'b0);
    chk("abort_err", err_b, 1'b0);
    chk("abort_rdata", rdata_b, 32'h0);
    req_b = 0;
    repeat (2) @(negedge clk);
    rst_b = 1;
    repeat (6) begin
      @(negedge clk);
      if (valid_b) seen = 1;
    end
    chk("abort_no_pulse", seen, 1'b0);
    access(1, 1'b0, 32'h30, 3'b010, 32'h0, rd, e, cyc, sok);
    chk("abort_no_write", rd, 32'hA5A5A5A5);
    chk("l4_load_cycle", cyc, 5);
    chk("l4_stall", sok, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
